// File: rtl/mp64_extmem_mc.sv
// Multi-channel burst memory controller: fixed-priority arbitration with a
// starvation guard, one burst at a time onto a single-beat-handshake PHY.
module mp64_extmem_mc #(
  parameter int NCH    = 3,
  parameter int DW     = 64,
  parameter int AW     = 32,
  parameter int LENW   = 3,
  parameter int STARVE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NCH-1:0]       i_ch_req,
  input  logic [NCH-1:0]       i_ch_wen,
  input  logic [NCH*AW-1:0]    i_ch_addr,
  input  logic [NCH*LENW-1:0]  i_ch_len,
  input  logic [NCH*DW-1:0]    i_ch_wdata,
  output logic [NCH-1:0]       o_ch_wpop,
  output logic [NCH-1:0]       o_ch_gnt,
  output logic [NCH-1:0]       o_ch_rvalid,
  output logic [DW-1:0]        o_ch_rdata,
  output logic [NCH-1:0]       o_ch_done,
  output logic                 o_phy_req,
  output logic                 o_phy_wen,
  output logic [AW-1:0]        o_phy_addr,
  output logic [DW-1:0]        o_phy_wdata,
  output logic [LENW:0]        o_phy_burst_len,
  input  logic [DW-1:0]        i_phy_rdata,
  input  logic                 i_phy_ack
);

  localparam int GW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WCW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
  localparam logic [AW-1:0] BEAT_BYTES = AW'(DW / 8);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                   r_state, w_next;
  logic [GW-1:0]            r_g, w_win;
  logic                     r_wen;
  logic [LENW-1:0]          r_len, r_beat;
  logic [NCH-1:0][WCW-1:0]  r_wc;

  logic                     w_any, w_grant, w_beat, w_last, w_win_wen;
  logic [AW-1:0]            w_win_addr;
  logic [LENW-1:0]          w_win_len;
  logic [DW-1:0]            w_win_wdata, w_cur_wdata;

  assign w_any   = |i_ch_req;
  assign w_grant = (r_state == S_IDLE) && w_any;
  assign w_beat  = (r_state == S_BURST) && i_phy_ack;
  assign w_last  = (r_beat == r_len);

  // Lowest requester wins; a starved requester (lowest index first) overrides.
  always_comb begin
    w_win = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (i_ch_req[i]) w_win = GW'(i);
    if (STARVE > 0)
      for (int i = NCH - 1; i >= 0; i--)
        if (i_ch_req[i] && int'(r_wc[i]) >= STARVE) w_win = GW'(i);
  end

  always_comb begin
    w_win_addr  = '0;
    w_win_len   = '0;
    w_win_wdata = '0;
    w_win_wen   = 1'b0;
    w_cur_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_win == GW'(i)) begin
        w_win_addr  = i_ch_addr[i*AW +: AW];
        w_win_len   = i_ch_len[i*LENW +: LENW];
        w_win_wdata = i_ch_wdata[i*DW +: DW];
        w_win_wen   = i_ch_wen[i];
      end
      if (r_g == GW'(i)) w_cur_wdata = i_ch_wdata[i*DW +: DW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_BURST;
      S_BURST: if (w_beat && w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The last beat pops nothing: its word was already taken on the previous ack.
  always_comb begin
    o_ch_wpop = '0;
    if (i_rst_n) begin
      if (w_grant && w_win_wen)            o_ch_wpop[w_win] = 1'b1;
      else if (w_beat && r_wen && !w_last) o_ch_wpop[r_g]   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_g             <= '0;
      r_wen           <= 1'b0;
      r_len           <= '0;
      r_beat          <= '0;
      o_phy_req       <= 1'b0;
      o_phy_wen       <= 1'b0;
      o_phy_addr      <= '0;
      o_phy_wdata     <= '0;
      o_phy_burst_len <= '0;
      o_ch_rdata      <= '0;
      o_ch_gnt        <= '0;
      o_ch_rvalid     <= '0;
      o_ch_done       <= '0;
    end else begin
      o_ch_gnt    <= '0;
      o_ch_rvalid <= '0;
      o_ch_done   <= '0;
      if (w_grant) begin
        r_g             <= w_win;
        r_wen           <= w_win_wen;
        r_len           <= w_win_len;
        r_beat          <= '0;
        o_phy_req       <= 1'b1;
        o_phy_wen       <= w_win_wen;
        o_phy_addr      <= w_win_addr;
        o_phy_wdata     <= w_win_wdata;
        o_phy_burst_len <= {1'b0, w_win_len} + (LENW+1)'(1);
        o_ch_gnt[w_win] <= 1'b1;
      end else if (w_beat) begin
        if (!r_wen) begin
          o_ch_rdata       <= i_phy_rdata;
          o_ch_rvalid[r_g] <= 1'b1;
        end
        if (w_last) begin
          o_phy_req      <= 1'b0;
          o_ch_done[r_g] <= 1'b1;
        end else begin
          r_beat     <= r_beat + LENW'(1);
          o_phy_addr <= o_phy_addr + BEAT_BYTES;
          if (r_wen) o_phy_wdata <= w_cur_wdata;
        end
      end
    end
  end

  // Wait counters only advance on real grants; saturate once starved.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (!i_rst_n || !i_ch_req[i]) r_wc[i] <= '0;
      else if (w_grant) begin
        if (w_win == GW'(i))             r_wc[i] <= '0;
        else if (int'(r_wc[i]) < STARVE) r_wc[i] <= r_wc[i] + WCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mp64_extmem_mc.sv
// Randomized and directed bench for mp64_extmem_mc against a transaction-level
// model of arbitration, burst beats, write-source consumption and read return.
module tb_mp64_extmem_mc;
  localparam int NCH = 3, DW = 64, AW = 32, LENW = 3, STARVE = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NCH-1:0]      ch_req, ch_wen, ch_wpop, ch_gnt, ch_rvalid, ch_done;
  logic [NCH*AW-1:0]   ch_addr;
  logic [NCH*LENW-1:0] ch_len;
  logic [NCH*DW-1:0]   ch_wdata;
  logic [DW-1:0]       ch_rdata, phy_wdata, phy_rdata;
  logic                phy_req, phy_wen, phy_ack;
  logic [AW-1:0]       phy_addr;
  logic [LENW:0]       phy_burst_len;

  always #5 clk = ~clk;

  mp64_extmem_mc #(.NCH(NCH), .DW(DW), .AW(AW), .LENW(LENW), .STARVE(STARVE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_req(ch_req), .i_ch_wen(ch_wen),
    .i_ch_addr(ch_addr), .i_ch_len(ch_len), .i_ch_wdata(ch_wdata),
    .o_ch_wpop(ch_wpop), .o_ch_gnt(ch_gnt), .o_ch_rvalid(ch_rvalid),
    .o_ch_rdata(ch_rdata), .o_ch_done(ch_done), .o_phy_req(phy_req),
    .o_phy_wen(phy_wen), .o_phy_addr(phy_addr), .o_phy_wdata(phy_wdata),
    .o_phy_burst_len(phy_burst_len), .i_phy_rdata(phy_rdata), .i_phy_ack(phy_ack));

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // requester agents (one descriptor per channel) and FWFT write sources
  bit             act[NCH], d_wen[NCH];
  logic [AW-1:0]  d_addr[NCH];
  logic [LENW-1:0] d_len[NCH];
  int             reps[NCH], pcnt[NCH];
  logic [DW-1:0]  wbase[NCH];
  // PHY agent
  bit             rnd, use_fixed;
  int             ack_wait, wcnt;
  logic [DW-1:0]  rd_fixed;
  // reference model
  bit             m_busy, m_wen;
  int             m_g, m_len, m_k, m_wstart;
  logic [AW-1:0]  m_base, addr_b1;
  logic [DW-1:0]  m_rdata;
  int             wc[NCH], widx[NCH];
  int             gq[$];
  logic [NCH-1:0] p_req;
  bit             p_beat, p_rst, rst_drv;
  logic [DW-1:0]  p_rd;

  function automatic int arb(input logic [NCH-1:0] req);
    if (STARVE > 0)
      for (int i = 0; i < NCH; i++) if (req[i] && wc[i] >= STARVE) return i;
    for (int i = 0; i < NCH; i++) if (req[i]) return i;
    return -1;
  endfunction

  function automatic bit any_act();
    for (int i = 0; i < NCH; i++) if (act[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    logic [NCH-1:0] eg, ev, ed, ew;
    logic [AW-1:0]  ea;
    int w;
    @(negedge clk);
    eg = '0; ev = '0; ed = '0;
    if (!p_rst) begin
      chk("rst_phy_req", phy_req, 0);     chk("rst_phy_wen", phy_wen, 0);
      chk("rst_phy_addr", phy_addr, 0);   chk("rst_phy_wdata", phy_wdata, 0);
      chk("rst_blen", phy_burst_len, 0);  chk("rst_rdata", ch_rdata, 0);
      chk("rst_gnt", ch_gnt, 0);          chk("rst_rvalid", ch_rvalid, 0);
      chk("rst_done", ch_done, 0);
      m_busy = 0; m_rdata = '0;
      for (int i = 0; i < NCH; i++) begin wc[i] = 0; widx[i] = pcnt[i]; end
    end else begin
      if (!m_busy && p_req != '0) begin
        w = arb(p_req); eg[w] = 1'b1; gq.push_back(w);
        m_busy = 1; m_g = w; m_wen = d_wen[w]; m_base = d_addr[w];
        m_len = int'(d_len[w]); m_k = 0; m_wstart = widx[w];
        if (m_wen) widx[w] += m_len + 1;
        for (int i = 0; i < NCH; i++) wc[i] = (!p_req[i] || i == w) ? 0 : wc[i] + 1;
        if (reps[w] > 0) reps[w]--;
        else begin
          act[w] = 0; d_addr[w] = AW'($urandom);
          d_len[w] = LENW'($urandom); d_wen[w] = 1'($urandom);
        end
      end else begin
        for (int i = 0; i < NCH; i++) if (!p_req[i]) wc[i] = 0;
        if (m_busy && p_beat) begin
          if (!m_wen) begin ev[m_g] = 1'b1; m_rdata = p_rd; end
          m_k++;
          if (m_k == m_len + 1) begin ed[m_g] = 1'b1; m_busy = 0; end
        end
      end
      chk("gnt", ch_gnt, eg);      chk("rvalid", ch_rvalid, ev);
      chk("done", ch_done, ed);    chk("rdata", ch_rdata, m_rdata);
      chk("phy_req", phy_req, m_busy);
      if (m_busy) begin
        ea = m_base + AW'(m_k * (DW / 8));
        if (m_k == 1) addr_b1 = phy_addr;
        chk("phy_addr", phy_addr, ea);
        chk("phy_blen", phy_burst_len, m_len + 1);
        chk("phy_wen", phy_wen, m_wen);
        if (m_wen) chk("phy_wdata", phy_wdata, wbase[m_g] + DW'(m_wstart + m_k));
      end
    end
    // drive next cycle's inputs
    rst_n = rst_drv;
    for (int i = 0; i < NCH; i++) begin
      ch_req[i] = act[i];
      ch_wen[i] = d_wen[i];
      ch_addr[i*AW +: AW] = d_addr[i];
      ch_len[i*LENW +: LENW] = d_len[i];
      ch_wdata[i*DW +: DW] = wbase[i] + DW'(pcnt[i]);
    end
    if (phy_req) phy_ack = rnd ? ($urandom_range(2) != 0) : (wcnt >= ack_wait);
    else         phy_ack = rnd ? 1'($urandom) : 1'b0;
    phy_rdata = use_fixed ? rd_fixed : {$urandom, $urandom};
    wcnt   = (phy_req && !phy_ack) ? wcnt + 1 : 0;
    p_beat = phy_req && phy_ack;
    p_rd   = phy_rdata;
    p_req  = ch_req;
    p_rst  = rst_drv;
    #1;
    ew = '0;
    if (rst_drv) begin
      if (!m_busy && ch_req != '0) begin
        w = arb(ch_req);
        if (d_wen[w]) ew[w] = 1'b1;
      end else if (m_busy && p_beat && m_wen && m_k != m_len) ew[m_g] = 1'b1;
    end
    chk("wpop", ch_wpop, ew);
    for (int i = 0; i < NCH; i++) pcnt[i] += int'(ch_wpop[i]);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((any_act() || m_busy) && n < maxc) begin step(); n++; end
    chk("drain_in_budget", n < maxc, 1'b1);
    step(); step();
  endtask

  task automatic req(input int c, input bit wen, input logic [AW-1:0] a, input int len, input int r);
    d_wen[c] = wen; d_addr[c] = a; d_len[c] = LENW'(len); reps[c] = r; act[c] = 1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ch_req = '0; ch_wen = '0; ch_addr = '0; ch_len = '0; ch_wdata = '0;
    phy_ack = 1'b0; phy_rdata = '0;
    p_rst = 0; rst_drv = 0; p_req = '0; p_beat = 0; p_rd = '0;
    rnd = 0; use_fixed = 0; ack_wait = 0; wcnt = 0; rd_fixed = '0; addr_b1 = '0;
    m_busy = 0; m_rdata = '0; m_g = 0; m_wen = 0; m_len = 0; m_k = 0; m_wstart = 0; m_base = '0;
    for (int i = 0; i < NCH; i++) begin
      act[i] = 0; d_wen[i] = 0; d_addr[i] = '0; d_len[i] = '0; reps[i] = 0;
      pcnt[i] = 0; widx[i] = 0; wc[i] = 0; wbase[i] = '0;
    end
    step(); step();
    rst_drv = 1;
    step();

    // single read, PHY acks two cycles into the request
    use_fixed = 1; rd_fixed = 64'hDEADBEEF_00000001; ack_wait = 2;
    req(1, 0, 32'h0000_1000, 0, 0);
    drain(50);
    chk("rd1_rdata_hold", ch_rdata, 64'hDEADBEEF_00000001);
    use_fixed = 0; ack_wait = 0;

    // 8-beat write from a 0..7 source, zero-wait PHY
    req(0, 1, 32'h0000_2000, 7, 0);
    drain(50);
    chk("wr8_pops", pcnt[0], 8);

    // three simultaneous single-beat requests
    gq.delete();
    req(0, 0, 32'h100, 0, 0); req(1, 0, 32'h200, 0, 0); req(2, 0, 32'h300, 0, 0);
    drain(50);
    chk("prio_g0", gq[0], 0); chk("prio_g1", gq[1], 1); chk("prio_g2", gq[2], 2);

    // ch0 keeps re-requesting, ch2 must break in after two ch0 grants
    gq.delete();
    req(0, 0, 32'h400, 0, 3); req(2, 0, 32'h500, 0, 0);
    drain(80);
    chk("starve_g0", gq[0], 0); chk("starve_g1", gq[1], 0); chk("starve_g2", gq[2], 2);

    // address wrap at the top of the space
    req(1, 1, 32'hFFFF_FFF8, 1, 0);
    drain(50);
    chk("wrap_beat1_addr", addr_b1, 32'h0000_0000);

    // reset in the middle of an 8-beat read
    req(0, 0, 32'h3000, 7, 0);
    n = 0;
    while (!(m_busy && m_k == 3) && n < 40) begin step(); n++; end
    chk("reached_beat3", n < 40, 1'b1);
    rst_drv = 0; step();
    rst_drv = 1; step();
    gq.delete();
    req(2, 0, 32'h6000, 2, 0);
    drain(50);
    chk("post_rst_grant", gq.size() > 0 ? gq[0] : -1, 2);

    // random traffic with a wait-stating PHY and stray acks
    rnd = 1;
    for (int i = 0; i < NCH; i++) wbase[i] = {$urandom, $urandom};
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < NCH; i++)
        if (!act[i] && $urandom_range(3) == 0)
          req(i, 1'($urandom), AW'($urandom), int'($urandom_range(7)), int'($urandom_range(1)));
      step();
    end
    drain(400);
    rnd = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
